// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: op encoding (funct3),
// FSM states, fixed latency and the decoder's M-extension qualifier.
package ex_muldiv_seq_pkg;

   localparam int MULDIV_XLEN    = 32;
   localparam int MULDIV_LATENCY = MULDIV_XLEN + 2;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } seq_state_e;

   // OP opcode with funct7=0000001 selects the M extension.
   function automatic logic is_muldiv(input logic [6:0] funct7, input logic [6:0] opcode);
      return (funct7 == 7'b0000001) && (opcode == 7'b0110011);
   endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer handshake: op issue, flush, stall and result.
interface ex_muldiv_seq_if
   import ex_muldiv_seq_pkg::*;
#(
   parameter int XLEN = 32
);

   logic             start_i;
   muldiv_op_e       op_i;
   logic [XLEN-1:0]  a_i;
   logic [XLEN-1:0]  b_i;
   logic             flush_i;
   logic             busy_o;
   logic             stall_o;
   logic             done_o;
   logic [XLEN-1:0]  result_o;

   modport master (
      output start_i, op_i, a_i, b_i, flush_i,
      input  busy_o, stall_o, done_o, result_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i, flush_i,
      output busy_o, stall_o, done_o, result_o
   );

endinterface

// File: rtl/ex_muldiv_seq_step.sv
// One combinational iteration of the shared datapath: right-shifting shift-add
// multiply or left-shifting restoring divide over the {acc, q} register pair.
module ex_muldiv_seq_step #(
   parameter int XLEN = 32
) (
   input  logic            div_mode,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] q,
   input  logic [XLEN-1:0] m,
   output logic [XLEN-1:0] acc_nxt,
   output logic [XLEN-1:0] q_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rem_sh;
   logic          fits;

   always_comb begin
      sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
      rem_sh  = {acc, q[XLEN-1]};
      fits    = (rem_sh >= {1'b0, m});
      acc_nxt = sum[XLEN:1];
      q_nxt   = {sum[0], q[XLEN-1:1]};
      if (div_mode) begin
         // rem_sh - m always fits in XLEN bits when the subtraction is taken.
         if (fits) begin
            acc_nxt = rem_sh[XLEN-1:0] - m;
            q_nxt   = {q[XLEN-2:0], 1'b1};
         end else begin
            acc_nxt = rem_sh[XLEN-1:0];
            q_nxt   = {q[XLEN-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage. Stalls the front end
// while the shared datapath iterates XLEN times, then presents result_o for one cycle.
module ex_muldiv_seq
   import ex_muldiv_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   ex_muldiv_seq_if.slave bus
);

   localparam int              CNT_W   = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   muldiv_op_e       op_q;
   logic             div_q;
   logic             neg_lo_q;
   logic             neg_rem_q;
   logic [XLEN-1:0]  acc_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  opnd_q;
   logic [XLEN-1:0]  result_q;

   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic             sign_a, sign_b;
   logic             is_div, quo_op, signed_div;
   logic             div_zero, div_ovf, special, launch, last_iter;
   logic [XLEN-1:0]  mag_a, mag_b, special_res;
   logic [XLEN-1:0]  acc_nxt, quo_nxt;

   function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
      return neg ? -v : v;
   endfunction

   // Sign fix-up and half/quotient/remainder select on the final iteration's output.
   function automatic logic [XLEN-1:0] fix_result(
      input muldiv_op_e      op,
      input logic [XLEN-1:0] hi,
      input logic [XLEN-1:0] lo,
      input logic            neg_lo,
      input logic            neg_rem
   );
      logic [2*XLEN-1:0] prod;
      prod = neg_lo ? -{hi, lo} : {hi, lo};
      case (op)
         MD_MUL:                       return prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: return prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              return negate_if(neg_lo, lo);
         MD_REM, MD_REMU:              return negate_if(neg_rem, hi);
         default:                      return '0;
      endcase
   endfunction

   // Operand decode for a new op: signedness, magnitudes and the skip-CALC cases.
   always_comb begin
      a_s        = $signed(bus.a_i);
      b_s        = $signed(bus.b_i);
      sign_a     = 1'b0;
      sign_b     = 1'b0;
      is_div     = 1'b0;
      quo_op     = 1'b0;
      signed_div = 1'b0;
      case (bus.op_i)
         MD_MULH: begin
            sign_a = (a_s < 0);
            sign_b = (b_s < 0);
         end
         MD_MULHSU: sign_a = (a_s < 0);
         MD_DIV: begin
            sign_a     = (a_s < 0);
            sign_b     = (b_s < 0);
            is_div     = 1'b1;
            quo_op     = 1'b1;
            signed_div = 1'b1;
         end
         MD_DIVU: begin
            is_div = 1'b1;
            quo_op = 1'b1;
         end
         MD_REM: begin
            sign_a     = (a_s < 0);
            sign_b     = (b_s < 0);
            is_div     = 1'b1;
            signed_div = 1'b1;
         end
         MD_REMU: is_div = 1'b1;
         default: ;
      endcase
      mag_a    = negate_if(sign_a, bus.a_i);
      mag_b    = negate_if(sign_b, bus.b_i);
      div_zero = (bus.b_i == '0);
      div_ovf  = signed_div && (bus.a_i == INT_MIN) && (bus.b_i == '1);
      special  = is_div && (div_zero || div_ovf);
      if (div_zero) begin
         special_res = quo_op ? '1 : bus.a_i;
      end else begin
         special_res = quo_op ? INT_MIN : '0;
      end
   end

   assign launch    = bus.start_i && !bus.flush_i && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign last_iter = (cnt_q == CNT_W'(1));

   ex_muldiv_seq_step #(.XLEN(XLEN)) u_step (
      .div_mode (div_q),
      .acc      (acc_q),
      .q        (quo_q),
      .m        (opnd_q),
      .acc_nxt  (acc_nxt),
      .q_nxt    (quo_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; flush overrides every transition.
   always_comb begin
      state_d     = state_q;
      bus.busy_o  = (state_q != S_IDLE);
      bus.stall_o = ((state_q == S_IDLE) && bus.start_i) || (state_q == S_CALC);
      bus.done_o  = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (launch) state_d = special ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (last_iter) state_d = S_DONE;
         end
         S_DONE: begin
            if (launch) state_d = special ? S_DONE : S_CALC;
            else        state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.flush_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         op_q      <= MD_MUL;
         div_q     <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         quo_q     <= '0;
         opnd_q    <= '0;
         result_q  <= '0;
      end else if (launch) begin
         cnt_q     <= CNT_W'(XLEN);
         op_q      <= bus.op_i;
         div_q     <= is_div;
         neg_lo_q  <= sign_a ^ sign_b;
         neg_rem_q <= sign_a;
         acc_q     <= '0;
         quo_q     <= mag_a;
         opnd_q    <= mag_b;
         if (special) result_q <= special_res;
      end else if (state_q == S_CALC) begin
         cnt_q <= cnt_q - CNT_W'(1);
         acc_q <= acc_nxt;
         quo_q <= quo_nxt;
         if (last_iter && !bus.flush_i) begin
            result_q <= fix_result(op_q, acc_nxt, quo_nxt, neg_lo_q, neg_rem_q);
         end
      end
   end

   assign bus.result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: scenario tasks plus a result scoreboard
// that pops one expected value per done_o pulse.
module tb_ex_muldiv_seq;
   import ex_muldiv_seq_pkg::*;

   typedef struct {
      logic [31:0] res;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   ex_muldiv_seq_if #(.XLEN(32)) bus ();

   ex_muldiv_seq #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Scoreboard: every done_o pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done_o) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: result_o=%h with no op pending", bus.result_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (bus.result_o !== e.res) begin
               n_fail++;
               $display("FAIL %s: result_o=%h expected %h", e.name, bus.result_o, e.res);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model(input muldiv_op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint          as_v, bs_v;
      longint unsigned au, bu;
      logic [63:0]     p;
      as_v = longint'($signed(a));
      bs_v = longint'($signed(b));
      au   = {32'd0, a};
      bu   = {32'd0, b};
      p    = '0;
      case (op)
         MD_MUL:    begin p = au * bu;            return p[31:0];  end
         MD_MULH:   begin p = as_v * bs_v;        return p[63:32]; end
         MD_MULHSU: begin p = as_v * longint'(bu); return p[63:32]; end
         MD_MULHU:  begin p = au * bu;            return p[63:32]; end
         MD_DIV: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            p = as_v / bs_v;
            return p[31:0];
         end
         MD_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            p = as_v % bs_v;
            return p[31:0];
         end
         MD_DIVU: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            p = au / bu;
            return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            p = au % bu;
            return p[31:0];
         end
      endcase
   endfunction

   // Issue one op from IDLE; report cycles to done_o (0 on timeout) and stall cycles.
   task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input string name,
                         output int lat, output int stalls);
      exp_t e;
      e.res  = exp_res;
      e.name = name;
      sb_q.push_back(e);
      @(posedge clk); #1;
      bus.op_i    = op;
      bus.a_i     = a;
      bus.b_i     = b;
      bus.start_i = 1'b1;
      lat    = 0;
      stalls = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (bus.stall_o) stalls++;
         if (bus.done_o) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
         bus.start_i = 1'b0;
      end
      bus.start_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks += 4;
      if (bus.busy_o !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
      if (bus.done_o !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
      if (bus.result_o !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks += 2;
      if (bus.busy_o !== 1'b0)    begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.busy_o); end
      if (bus.result_o !== 32'd0) begin n_fail++; $display("FAIL idle_result: got %h want 0", bus.result_o); end
   endtask

   task automatic test_mul();
      int lat, stalls;
      run_op(MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3", lat, stalls);
      n_checks += 2;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, MULDIV_LATENCY); end
      if (stalls !== 33) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d want 33", stalls); end
   endtask

   task automatic test_mulh();
      int lat, stalls;
      run_op(MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1_m1", lat, stalls);
      n_checks++;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL mulh_latency: got %0d want 34", lat); end
      run_op(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max", lat, stalls);
      n_checks++;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL mulhu_latency: got %0d want 34", lat); end
      run_op(MD_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu_m1_2", lat, stalls);
      n_checks++;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL mulhsu_latency: got %0d want 34", lat); end
   endtask

   task automatic test_div();
      int lat, stalls;
      run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2", lat, stalls);
      n_checks++;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL div_latency: got %0d want 34", lat); end
      run_op(MD_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2", lat, stalls);
      n_checks++;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL rem_latency: got %0d want 34", lat); end
      run_op(MD_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7", lat, stalls);
      n_checks++;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL divu_latency: got %0d want 34", lat); end
      run_op(MD_REMU, 32'd100, 32'd7, 32'd2, "remu_100_7", lat, stalls);
      n_checks++;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL remu_latency: got %0d want 34", lat); end
   endtask

   task automatic test_special();
      int lat, stalls;
      run_op(MD_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, "div_by_zero", lat, stalls);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL div0_latency: got %0d want 2", lat); end
      run_op(MD_REM, 32'd5, 32'd0, 32'd5, "rem_by_zero", lat, stalls);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL rem0_latency: got %0d want 2", lat); end
      run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_overflow", lat, stalls);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL divovf_latency: got %0d want 2", lat); end
      run_op(MD_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_overflow", lat, stalls);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL removf_latency: got %0d want 2", lat); end
      run_op(MD_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, "divu_by_zero", lat, stalls);
      n_checks += 2;
      if (lat !== 2) begin n_fail++; $display("FAIL divu0_latency: got %0d want 2", lat); end
      if (stalls !== 1) begin n_fail++; $display("FAIL special_stall_cycles: got %0d want 1", stalls); end
   endtask

   task automatic test_flush();
      int dones = 0;
      int lat, stalls;
      @(posedge clk); #1;
      bus.op_i = MD_MUL; bus.a_i = 32'd1234; bus.b_i = 32'd5678; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL flush_calc_stall: got %b want 1", bus.stall_o); end
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      n_checks += 3;
      if (bus.busy_o !== 1'b0)  begin n_fail++; $display("FAIL flush_busy: got %b want 0", bus.busy_o); end
      if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", bus.stall_o); end
      if (bus.done_o !== 1'b0)  begin n_fail++; $display("FAIL flush_done: got %b want 0", bus.done_o); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done_o) dones++;
      end
      n_checks++;
      if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
      // Flush beats start in the same cycle.
      @(posedge clk); #1;
      bus.op_i = MD_DIVU; bus.a_i = 32'd50; bus.b_i = 32'd5; bus.start_i = 1'b1; bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      n_checks++;
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_priority_busy: got %b want 0", bus.busy_o); end
      run_op(MD_MUL, 32'd1234, 32'd5678, 32'd7006652, "after_flush_mul", lat, stalls);
      n_checks++;
      if (lat !== MULDIV_LATENCY) begin n_fail++; $display("FAIL after_flush_latency: got %0d want 34", lat); end
   endtask

   task automatic test_back_to_back();
      exp_t e1, e2;
      int   lat = 0;
      bit   found = 0;
      e1.res = 32'd100;        e1.name = "b2b_first_divu";
      e2.res = 32'hFFFFFFF7;   e2.name = "b2b_second_rem";
      sb_q.push_back(e1);
      sb_q.push_back(e2);
      @(posedge clk); #1;
      bus.op_i = MD_DIVU; bus.a_i = 32'd1000; bus.b_i = 32'd10; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.done_o) begin
            found = 1;
            break;
         end
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL b2b_first_done: got none want pulse"); end
      bus.op_i = MD_REM; bus.a_i = 32'hFFFFFF9C; bus.b_i = 32'd13; bus.start_i = 1'b1;
      #1;
      n_checks++;
      if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done_stall: got %b want 0", bus.stall_o); end
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      n_checks += 2;
      if (bus.busy_o !== 1'b1)  begin n_fail++; $display("FAIL b2b_calc_busy: got %b want 1", bus.busy_o); end
      if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_calc_stall: got %b want 1", bus.stall_o); end
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (bus.done_o) begin
            lat = c;
            break;
         end
      end
      n_checks++;
      if (lat !== 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
   endtask

   task automatic test_reset_mid_calc();
      int dones = 0;
      @(posedge clk); #1;
      bus.op_i = MD_MULHU; bus.a_i = 32'hDEADBEEF; bus.b_i = 32'h12345678; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks += 4;
      if (bus.busy_o !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy_o); end
      if (bus.stall_o !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", bus.stall_o); end
      if (bus.done_o !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", bus.done_o); end
      if (bus.result_o !== 32'd0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", bus.result_o); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done_o) dones++;
      end
      n_checks++;
      if (dones !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", dones); end
   endtask

   task automatic test_random();
      int          lat, stalls, want_lat;
      muldiv_op_e  op;
      logic [31:0] a, b;
      for (int i = 0; i < 10; i++) begin
         op = muldiv_op_e'(3'($urandom_range(0, 7)));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         want_lat = MULDIV_LATENCY;
         if (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && b == 32'd0) want_lat = 2;
         if (op inside {MD_DIV, MD_REM} && a == 32'h80000000 && b == 32'hFFFFFFFF) want_lat = 2;
         run_op(op, a, b, model(op, a, b), $sformatf("rand%0d_op%0d", i, op), lat, stalls);
         n_checks++;
         if (lat !== want_lat) begin
            n_fail++;
            $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, want_lat);
         end
      end
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.op_i    = MD_MUL;
      bus.a_i     = '0;
      bus.b_i     = '0;
      rst_n       = 1'b0;
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_special();
      test_flush();
      test_back_to_back();
      test_reset_mid_calc();
      test_random();
      repeat (2) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drained: got %0d pending want 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
